// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode seven-segment display.
// Double-buffered display word, blanking gap per slot, optional leading-zero suppression.
module seg_scan_ctrl #(
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        LOAD,
    input  logic [15:0] DATA,
    input  logic        LZS,
    output logic        PEND,
    output logic        FRAME,
    output logic [3:0]  DIGIT,
    output logic [3:0]  AN
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);

    typedef enum logic {
        PH_BLANK,
        PH_DRIVE
    } phase_e;

    localparam phase_e PH_RESET = (BLANK > 0) ? PH_BLANK : PH_DRIVE;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      disp_q, disp_d;
    logic [15:0]      pend_data_q, pend_data_d;
    logic             pend_q, pend_d;
    logic             frame_q, frame_d;
    logic [3:0]       an_q, an_d;
    logic [3:0]       digit_q, digit_d;
    phase_e           phase_q, phase_d;

    logic             slot_end;
    logic             boundary;
    logic [3:0]       supp;

    assign slot_end = (cnt_q == CNT_LAST);
    assign boundary = slot_end && (idx_q == 2'd3);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (slot_end) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    // The shown word only changes at the frame boundary; a LOAD there bypasses the buffer.
    always_comb begin
        disp_d      = disp_q;
        pend_data_d = pend_data_q;
        pend_d      = pend_q;
        frame_d     = boundary;
        if (boundary) begin
            if (LOAD) begin
                disp_d = DATA;
                pend_d = 1'b0;
            end else if (pend_q) begin
                disp_d = pend_data_q;
                pend_d = 1'b0;
            end
        end else if (LOAD) begin
            pend_data_d = DATA;
            pend_d      = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            phase_q <= PH_RESET;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Phase tracks the counter value the slot will hold next cycle.
    always_comb begin
        phase_d = PH_DRIVE;
        if ((BLANK != 0) && (cnt_d < CNT_BLANK)) begin
            phase_d = PH_BLANK;
        end
    end

    always_comb begin
        supp    = 4'b0000;
        supp[3] = (disp_q[15:12] == 4'h0);
        supp[2] = supp[3] && (disp_q[11:8] == 4'h0);
        supp[1] = supp[2] && (disp_q[7:4] == 4'h0);
        supp    = LZS ? supp : 4'b0000;
    end

    always_comb begin
        an_d    = 4'b1111;
        digit_d = 4'hF;
        case (phase_q)
            PH_DRIVE: begin
                if (!supp[idx_q]) begin
                    an_d    = ~(4'b0001 << idx_q);
                    digit_d = disp_q[{idx_q, 2'b00} +: 4];
                end
            end
            default: begin
                an_d    = 4'b1111;
                digit_d = 4'hF;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            disp_q      <= 16'h0000;
            pend_data_q <= 16'h0000;
            pend_q      <= 1'b0;
            frame_q     <= 1'b0;
            an_q        <= 4'b1111;
            digit_q     <= 4'hF;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            disp_q      <= disp_d;
            pend_data_q <= pend_data_d;
            pend_q      <= pend_d;
            frame_q     <= frame_d;
            an_q        <= an_d;
            digit_q     <= digit_d;
        end
    end

    assign PEND  = pend_q;
    assign FRAME = frame_q;
    assign DIGIT = digit_q;
    assign AN    = an_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: vector table, directed corner sequences and
// randomized traffic compared against a time-position reference model.
module tb_seg_scan_ctrl;

    localparam int P         = 8;
    localparam int B         = 2;
    localparam int FRAME_LEN = 4 * P;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        LOAD = 1'b0;
    logic [15:0] DATA = 16'h0000;
    logic        LZS = 1'b0;
    logic        PEND;
    logic        FRAME;
    logic [3:0]  DIGIT;
    logic [3:0]  AN;

    int checks = 0;
    int failures = 0;

    // Reference model: position in frame is cycles since reset modulo the frame length.
    int          m_t = 0;
    logic [15:0] m_disp = 16'h0000;
    logic [15:0] m_pend_data = 16'h0000;
    logic        m_pend = 1'b0;
    logic        last_boundary = 1'b0;

    typedef struct {
        logic        rst;
        logic        load;
        logic [15:0] data;
        logic        lzs;
        logic [3:0]  an;
        logic [3:0]  digit;
        logic        pend;
        logic        frame;
    } vec_t;

    vec_t vecs[14];

    seg_scan_ctrl #(.PRESCALE(P), .BLANK(B)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .LOAD  (LOAD),
        .DATA  (DATA),
        .LZS   (LZS),
        .PEND  (PEND),
        .FRAME (FRAME),
        .DIGIT (DIGIT),
        .AN    (AN)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, predict outputs from the model, compare after the edge.
    task automatic applyStimulus(input logic rst, input logic load, input logic [15:0] data,
                                 input logic lzs);
        int          pos;
        int          slot;
        int          c;
        logic        bnd;
        logic        supp;
        logic [15:0] shifted;
        logic [3:0]  one;
        logic [3:0]  e_an;
        logic [3:0]  e_digit;
        logic        e_frame;

        @(negedge CLK);
        RST  = rst;
        LOAD = load;
        DATA = data;
        LZS  = lzs;

        pos     = m_t % FRAME_LEN;
        slot    = pos / P;
        c       = pos % P;
        bnd     = (pos == FRAME_LEN - 1);
        shifted = m_disp >> (4 * slot);
        supp    = lzs && (slot != 0) && (shifted == 16'h0000);
        one     = 4'b0001 << slot;
        if (c < B || supp) begin
            e_an    = 4'b1111;
            e_digit = 4'hF;
        end else begin
            e_an    = ~one;
            e_digit = shifted[3:0];
        end
        e_frame = bnd;

        if (rst) begin
            e_an        = 4'b1111;
            e_digit     = 4'hF;
            e_frame     = 1'b0;
            m_t         = 0;
            m_disp      = 16'h0000;
            m_pend_data = 16'h0000;
            m_pend      = 1'b0;
            last_boundary = 1'b0;
        end else begin
            if (bnd) begin
                if (load) begin
                    m_disp = data;
                    m_pend = 1'b0;
                end else if (m_pend) begin
                    m_disp = m_pend_data;
                    m_pend = 1'b0;
                end
            end else if (load) begin
                m_pend_data = data;
                m_pend      = 1'b1;
            end
            m_t++;
            last_boundary = bnd;
        end

        @(posedge CLK);
        #1;
        checkOutput("model_an", 16'(AN), 16'(e_an));
        checkOutput("model_digit", 16'(DIGIT), 16'(e_digit));
        checkOutput("model_pend", 16'(PEND), 16'(m_pend));
        checkOutput("model_frame", 16'(FRAME), 16'(e_frame));
        checkOutput("an_onehot_low", 16'($countones(~AN) <= 1), 16'd1);
    endtask

    task automatic run_until_pos(input int target, input logic lzs);
        int n = 0;
        while ((m_t % FRAME_LEN) != target && n < 2 * FRAME_LEN) begin
            applyStimulus(1'b0, 1'b0, 16'($urandom), lzs);
            n++;
        end
        checkOutput("pos_reached", 16'(m_t % FRAME_LEN), 16'(target));
    endtask

    task automatic run_to_boundary(input logic lzs);
        int n = 0;
        do begin
            applyStimulus(1'b0, 1'b0, 16'($urandom), lzs);
            n++;
        end while (!last_boundary && n < 2 * FRAME_LEN);
        checkOutput("boundary_reached", 16'(last_boundary), 16'd1);
    endtask

    // Observe one whole frame and rebuild the word from what each anode showed.
    task automatic capture_frame(input logic lzs, output logic [15:0] word, output logic [3:0] mask);
        word = 16'h0000;
        mask = 4'b0000;
        for (int i = 0; i < FRAME_LEN; i++) begin
            applyStimulus(1'b0, 1'b0, 16'($urandom), lzs);
            for (int k = 0; k < 4; k++) begin
                if (AN[k] == 1'b0) begin
                    word[k*4 +: 4] = DIGIT;
                    mask[k]        = 1'b1;
                end
            end
        end
    endtask

    task automatic set_vec(input int i, input logic rst, input logic load, input logic [15:0] data,
                           input logic [3:0] an, input logic [3:0] digit, input logic pend);
        vecs[i].rst   = rst;
        vecs[i].load  = load;
        vecs[i].data  = data;
        vecs[i].lzs   = 1'b0;
        vecs[i].an    = an;
        vecs[i].digit = digit;
        vecs[i].pend  = pend;
        vecs[i].frame = 1'b0;
    endtask

    initial begin
        logic [15:0] word;
        logic [3:0]  mask;

        // Reset, then the first slot and a half with a LOAD at cycle 10 of the frame.
        set_vec(0, 1'b1, 1'b0, 16'hDEAD, 4'b1111, 4'hF, 1'b0);
        set_vec(1, 1'b0, 1'b0, 16'hBEEF, 4'b1111, 4'hF, 1'b0);
        set_vec(2, 1'b0, 1'b0, 16'h0000, 4'b1111, 4'hF, 1'b0);
        for (int i = 3; i <= 8; i++) set_vec(i, 1'b0, 1'b0, 16'h0F0F, 4'b1110, 4'h0, 1'b0);
        set_vec(9, 1'b0, 1'b0, 16'h0000, 4'b1111, 4'hF, 1'b0);
        set_vec(10, 1'b0, 1'b0, 16'h0000, 4'b1111, 4'hF, 1'b0);
        set_vec(11, 1'b0, 1'b1, 16'h1234, 4'b1101, 4'h0, 1'b1);
        set_vec(12, 1'b0, 1'b0, 16'h5678, 4'b1101, 4'h0, 1'b1);
        set_vec(13, 1'b0, 1'b0, 16'h0000, 4'b1101, 4'h0, 1'b1);

        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].load, vecs[i].data, vecs[i].lzs);
            checkOutput("vec_an", 16'(AN), 16'(vecs[i].an));
            checkOutput("vec_digit", 16'(DIGIT), 16'(vecs[i].digit));
            checkOutput("vec_pend", 16'(PEND), 16'(vecs[i].pend));
            checkOutput("vec_frame", 16'(FRAME), 16'(vecs[i].frame));
        end

        // First boundary: 32 cycles after release, pending 1234 becomes visible.
        run_to_boundary(1'b0);
        checkOutput("first_frame_time", 16'(m_t), 16'(FRAME_LEN));
        checkOutput("first_frame_pulse", 16'(FRAME), 16'd1);
        checkOutput("pend_cleared", 16'(PEND), 16'd0);
        capture_frame(1'b0, word, mask);
        checkOutput("frame_1234_word", word, 16'h1234);
        checkOutput("frame_1234_mask", 16'(mask), 16'hF);

        // Leading-zero suppression.
        run_until_pos(10, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'h0050, 1'b1);
        run_to_boundary(1'b1);
        capture_frame(1'b1, word, mask);
        checkOutput("lzs_0050_word", word, 16'h0050);
        checkOutput("lzs_0050_mask", 16'(mask), 16'h3);
        run_until_pos(5, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'h0000, 1'b1);
        run_to_boundary(1'b1);
        capture_frame(1'b1, word, mask);
        checkOutput("lzs_0000_word", word, 16'h0000);
        checkOutput("lzs_0000_mask", 16'(mask), 16'h1);

        // Last write wins.
        run_until_pos(9, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h1111, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h3333, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h2222, 1'b0);
        run_to_boundary(1'b0);
        capture_frame(1'b0, word, mask);
        checkOutput("overwrite_word", word, 16'h2222);

        // LOAD on the boundary cycle beats the pending word.
        run_until_pos(12, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h5555, 1'b0);
        run_until_pos(FRAME_LEN - 1, 1'b0);
        checkOutput("pend_before_bnd", 16'(PEND), 16'd1);
        applyStimulus(1'b0, 1'b1, 16'h9876, 1'b0);
        checkOutput("bnd_load_pend", 16'(PEND), 16'd0);
        capture_frame(1'b0, word, mask);
        checkOutput("bnd_load_word", word, 16'h9876);

        // Reset mid-DRIVE with a word pending.
        run_until_pos(12, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h4321, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("pend_mid", 16'(PEND), 16'd1);
        applyStimulus(1'b1, 1'b1, 16'h7777, 1'b0);
        checkOutput("rst_an", 16'(AN), 16'hF);
        checkOutput("rst_digit", 16'(DIGIT), 16'hF);
        checkOutput("rst_pend", 16'(PEND), 16'd0);
        checkOutput("rst_frame", 16'(FRAME), 16'd0);
        capture_frame(1'b0, word, mask);
        checkOutput("post_rst_word", word, 16'h0000);
        checkOutput("post_rst_mask", 16'(mask), 16'hF);
        checkOutput("post_rst_frame", 16'(FRAME), 16'd1);

        // Non-BCD nibbles with a nonzero top digit.
        run_until_pos(20, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'hA0B0, 1'b1);
        run_to_boundary(1'b1);
        capture_frame(1'b1, word, mask);
        checkOutput("nonbcd_word", word, 16'hA0B0);
        checkOutput("nonbcd_mask", 16'(mask), 16'hF);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) == 0),
                          16'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a 4-digit common-anode seven-segment display.
- Holds a 4-nibble BCD display word and steps through the digits one at a time.
- For the active digit it presents that digit's nibble on DIGIT, which feeds the existing BCD-to-segment decoder, and drives the matching active-low anode on AN.
- Provides double-buffered, tear-free loading, a blanking gap between digits to suppress ghosting, and optional leading-zero suppression.

Parameters:
- PRESCALE, 50000: clock cycles per digit slot; legal range >= 2.
- BLANK, 16: cycles at the start of each slot during which all anodes are off; legal range 0 <= BLANK < PRESCALE.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- LOAD  input  1  single-cycle strobe; capture DATA as the next display word.
- DATA  input  16  display word; [15:12] = digit 3 (most significant) ... [3:0] = digit 0.
- LZS  input  1  leading-zero suppression enable; sampled every cycle.
- PEND  output  1  a loaded word is waiting for the frame boundary.
- FRAME  output  1  one-cycle pulse at each frame boundary (end of the digit-3 slot).
- DIGIT  output  4  nibble for the decoder; 4'hF when blank.
- AN  output  4  anode enables, active-low; AN[k] drives digit k.

Behaviour:
- Internal state:
  - cnt: 0..PRESCALE-1, slot cycle counter.
  - idx: 0..3, slot index; scan order 0,1,2,3,0...
  - disp: 16-bit shown word.
  - pend_data: 16-bit pending word.
  - PEND flag.
- Reset (RST=1 at an edge, any time, including mid-slot or with a word pending):
  - cnt=0, idx=0, disp=16'h0000, pend_data=0.
  - Outputs: PEND=0, FRAME=0, AN=4'b1111, DIGIT=4'hF.
  - Any pending word is discarded. RST overrides LOAD.
- Counter: each cycle cnt increments. At cnt==PRESCALE-1, cnt becomes 0 and idx becomes (idx+1) mod 4.
- Frame boundary: the cycle with cnt==PRESCALE-1 and idx==3. In that cycle:
  - FRAME is registered high for exactly the next cycle.
  - If LOAD=1: disp<=DATA and PEND<=0. LOAD takes precedence over any pending word.
  - Otherwise, if PEND=1: disp<=pend_data and PEND<=0.
- LOAD outside the boundary cycle: pend_data<=DATA and PEND<=1. A repeated LOAD overwrites pend_data (last write wins). disp never changes mid-frame.
- Slot phase (per-slot state machine):
  - BLANK phase: cnt < BLANK.
  - DRIVE phase: cnt >= BLANK.
  - With BLANK=0 there is no BLANK phase.
- Suppression: with LZS=1, digit k (k=3,2,1) is suppressed when disp nibbles k..3 are all 4'h0. Digit 0 is never suppressed. With LZS=0 nothing is suppressed.
- Output computation: AN and DIGIT are registered, so they reflect the (cnt, idx, disp, LZS) values of the previous cycle.
  - BLANK phase, or suppressed digit: AN=4'b1111, DIGIT=4'hF.
  - DRIVE phase, not suppressed: AN = ~(4'b0001 << idx), DIGIT = disp nibble idx.
- Non-BCD nibbles (4'hA..4'hF) pass through unmodified; the downstream decoder blanks them.
- Exactly one anode, or none, is ever low. Never more than one.
- Slot length is exactly PRESCALE cycles; frame length is exactly 4*PRESCALE cycles.

Test Plan:
All scenarios use PRESCALE=8, BLANK=2.
1. Release RST, no LOAD, LZS=0 -> per slot: AN=1111 for 2 cycles, then 1110/1101/1011/0111 for 6 cycles each with DIGIT=0; FRAME pulses every 32 cycles, first pulse 32 cycles after reset release.
2. LOAD with DATA=16'h1234 at cycle 10 of a frame -> PEND=1 until the boundary; the current frame still shows 0000; the next frame shows DIGIT 4,3,2,1 on AN 1110,1101,1011,0111; PEND=0 after the boundary.
3. LZS=1, disp=16'h0050 -> slots 3 and 2 keep AN=1111 for the full slot; slot 1 shows 5; slot 0 shows 0. disp=16'h0000 -> only digit 0 is ever driven, showing 0.
4. LOAD 16'h1111 then 16'h2222 mid-frame -> the next frame shows 2222. LOAD 16'h9876 exactly on the boundary cycle with 16'h5555 pending -> the next frame shows 9876; PEND=0.
5. RST asserted mid-DRIVE with PEND=1 -> the following cycle has AN=1111, DIGIT=F, PEND=0, FRAME=0; after release, display 0000 starting at slot 0.
6. DATA=16'hA0B0 loaded, LZS=1 -> digit 3 is not suppressed (nonzero); DIGIT sequence 0,B,0,A; one-hot-low check on AN holds on every cycle.
